alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
Downstream stage of the 4-bit ALU op units (NOT/AND/OR/ADD...). It captures each op unit's result word, Z and CF flags, and an op tag into a small first-word-fall-through FIFO with a valid/ready handshake, so the consumer (register file write-back / display sequencer) can stall without losing results. It also keeps a sticky carry flag and a saturating count of zero-valued results for status readout.

Parameters:
WIDTH, 4, result word width in bits
DEPTH, 4, FIFO entries; power of 2, >= 2
TAGW, 3, op-tag width
CNTW, 8, zero-result counter width

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  reset, asynchronous assert, active-low
IN_VALID  input  1  upstream op unit presents a result
IN_READY  output  1  FIFO can accept this cycle
RES  input  WIDTH  result word from op unit
Z_IN  input  1  zero flag from op unit, stored unmodified
CF_IN  input  1  carry flag from op unit
OP_IN  input  TAGW  opcode tag of the producing op
OUT_VALID  output  1  head entry valid
OUT_READY  input  1  consumer accepts head entry
RES_OUT  output  WIDTH  head result
Z_OUT  output  1  head zero flag
CF_OUT  output  1  head carry flag
OP_OUT  output  TAGW  head op tag
COUNT  output  log2(DEPTH)+1  occupied entries
STICKY_CF  output  1  set if any accepted entry had CF_IN=1 since last clear
ZERO_CNT  output  CNTW  accepted entries with RES==0, saturating
CLR_STAT  input  1  synchronous clear of STICKY_CF and ZERO_CNT

Behaviour:
- Reset (RST_N=0, async): COUNT=0, read/write pointers=0, OUT_VALID=0, RES_OUT/Z_OUT/CF_OUT/OP_OUT=0, STICKY_CF=0, ZERO_CNT=0, IN_READY=1 once released. Reset mid-transfer discards all entries; no partial state survives.
- Push = IN_VALID & IN_READY; pop = OUT_VALID & OUT_READY. Data/ready/valid sampled on rising CLK.
- IN_READY = (COUNT < DEPTH), combinational from COUNT only; does NOT depend on OUT_READY (full FIFO never accepts, even with a simultaneous pop).
- OUT_VALID = (COUNT != 0). Outputs driven from head entry (FWFT); when OUT_VALID=0 outputs hold 0.
- Latency: entry pushed into empty FIFO at edge N is visible on outputs with OUT_VALID=1 after edge N (one cycle). No combinational input-to-output path.
- Push and pop same cycle: COUNT unchanged, both pointers advance. Pop alone: COUNT-1. Push alone: COUNT+1.
- Pointers wrap modulo DEPTH; COUNT range 0..DEPTH.
- Head outputs stable while OUT_VALID=1 and OUT_READY=0.
- IN_VALID while full: ignored, no state change; upstream must hold.
- STICKY_CF: set on push with CF_IN=1; cleared by CLR_STAT; same-cycle clear and setting push -> 1.
- ZERO_CNT: increments on push with RES==0 (evaluated on RES, independent of Z_IN); saturates at 2^CNTW-1; CLR_STAT sets it to 0, or to 1 if the same cycle pushes a zero RES.
- Z_IN/CF_IN/OP_IN carried per entry bit-exact; block does not reinterpret flag polarity.

Test Plan:
- Reset then single push RES=4'hA, CF_IN=0, OP_IN=3 with OUT_READY=0 -> next cycle OUT_VALID=1, RES_OUT=4'hA, OP_OUT=3, COUNT=1; held for 5 cycles unchanged.
- Push 5 entries 1,2,3,4,5 back-to-back, OUT_READY=0, DEPTH=4 -> IN_READY=0 after 4th push, COUNT=4, entry 5 not accepted; then OUT_READY=1 drains 1,2,3,4 in order, then 5 accepted.
- Full FIFO, IN_VALID=1 and OUT_READY=1 same cycle -> pop occurs, no push, COUNT=3; next cycle push accepted, COUNT back to 4 via simultaneous push/pop holds at 4.
- Stream 10 entries with random OUT_READY, pointers wrap twice -> output sequence identical to input sequence, no loss or duplication.
- Push RES=0 three times, one with CF_IN=1 -> ZERO_CNT=3, STICKY_CF=1; CLR_STAT with concurrent push RES=0, CF_IN=1 -> ZERO_CNT=1, STICKY_CF=1; CNTW=2 saturation test: 5 zero pushes -> ZERO_CNT=3.
- Assert RST_N=0 asynchronously mid-stream with COUNT=3 -> outputs zero immediately before next edge, COUNT=0, OUT_VALID=0, STICKY_CF=0.

Source files
------------

// File: rtl/alu_result_fifo.sv
// First-word-fall-through result FIFO behind the 4-bit ALU op units.
// Each entry holds the result, Z/CF flags and op tag. A sticky carry bit and a saturating zero-result count are kept alongside.
module alu_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int TAGW  = 3,
  parameter int CNTW  = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [WIDTH-1:0]           RES,
  input  logic                       Z_IN,
  input  logic                       CF_IN,
  input  logic [TAGW-1:0]            OP_IN,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [WIDTH-1:0]           RES_OUT,
  output logic                       Z_OUT,
  output logic                       CF_OUT,
  output logic [TAGW-1:0]            OP_OUT,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       STICKY_CF,
  output logic [CNTW-1:0]            ZERO_CNT,
  input  logic                       CLR_STAT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = WIDTH + 2 + TAGW;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            sticky_q, sticky_d;
  logic [CNTW-1:0] zcnt_q, zcnt_d;
  logic            push, pop, zero_push;
  logic [EW-1:0]   head;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    if (v == {CNTW{1'b1}}) return v;
    return v + 1'b1;
  endfunction

  assign IN_READY  = (count_q < CW'(DEPTH));
  assign OUT_VALID = (count_q != '0);
  assign push      = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;
  assign zero_push = push & (RES == '0);

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    zcnt_d   = zcnt_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A clear coinciding with a qualifying push keeps that push's contribution.
    if (CLR_STAT) begin
      sticky_d = push & CF_IN;
      zcnt_d   = zero_push ? CNTW'(1) : '0;
    end else begin
      if (push & CF_IN) sticky_d = 1'b1;
      if (zero_push)    zcnt_d   = sat_inc(zcnt_q);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
      zcnt_q   <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      zcnt_q   <= zcnt_d;
    end
  end

  // Storage needs no reset: stale words are never visible because outputs are gated by occupancy.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= {RES, Z_IN, CF_IN, OP_IN};
  end

  assign head = OUT_VALID ? mem_q[rptr_q] : '0;

  assign RES_OUT   = head[EW-1 -: WIDTH];
  assign Z_OUT     = head[TAGW+1];
  assign CF_OUT    = head[TAGW];
  assign OP_OUT    = head[TAGW-1:0];
  assign COUNT     = count_q;
  assign STICKY_CF = sticky_q;
  assign ZERO_CNT  = zcnt_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed and random steps checked against a queue-based reference model.
// A second instance with CNTW=2 receives the same stimulus and exercises zero-count saturation.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0] res;
    logic       z;
    logic       cf;
    logic [2:0] op;
  } ent_t;

  logic       CLK, RST_N;
  logic       IN_VALID, OUT_READY, CLR_STAT;
  logic [3:0] RES;
  logic       Z_IN, CF_IN;
  logic [2:0] OP_IN;

  logic       IN_READY, OUT_VALID, Z_OUT, CF_OUT, STICKY_CF;
  logic [3:0] RES_OUT;
  logic [2:0] OP_OUT;
  logic [2:0] COUNT;
  logic [7:0] ZERO_CNT;

  logic       s_in_ready, s_out_valid, s_z_out, s_cf_out, s_sticky;
  logic [3:0] s_res_out;
  logic [2:0] s_op_out;
  logic [2:0] s_count;
  logic [1:0] s_zero_cnt;

  int   ncmp  = 0;
  int   nfail = 0;
  ent_t mq[$];
  bit   m_sticky;
  int   m_zc8, m_zc2;

  alu_result_fifo #(.WIDTH(4), .DEPTH(DEPTH), .TAGW(3), .CNTW(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .RES(RES), .Z_IN(Z_IN), .CF_IN(CF_IN), .OP_IN(OP_IN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RES_OUT(RES_OUT),
    .Z_OUT(Z_OUT), .CF_OUT(CF_OUT), .OP_OUT(OP_OUT), .COUNT(COUNT),
    .STICKY_CF(STICKY_CF), .ZERO_CNT(ZERO_CNT), .CLR_STAT(CLR_STAT)
  );

  alu_result_fifo #(.WIDTH(4), .DEPTH(DEPTH), .TAGW(3), .CNTW(2)) u_sat (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(s_in_ready),
    .RES(RES), .Z_IN(Z_IN), .CF_IN(CF_IN), .OP_IN(OP_IN),
    .OUT_VALID(s_out_valid), .OUT_READY(OUT_READY), .RES_OUT(s_res_out),
    .Z_OUT(s_z_out), .CF_OUT(s_cf_out), .OP_OUT(s_op_out), .COUNT(s_count),
    .STICKY_CF(s_sticky), .ZERO_CNT(s_zero_cnt), .CLR_STAT(CLR_STAT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sticky = 1'b0;
    m_zc8 = 0;
    m_zc2 = 0;
  endtask

  task automatic check_all();
    ent_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("count",     32'(COUNT),     32'(mq.size()));
    chk("in_ready",  32'(IN_READY),  32'(mq.size() < DEPTH));
    chk("out_valid", 32'(OUT_VALID), 32'(mq.size() != 0));
    chk("res_out",   32'(RES_OUT),   32'(h.res));
    chk("z_out",     32'(Z_OUT),     32'(h.z));
    chk("cf_out",    32'(CF_OUT),    32'(h.cf));
    chk("op_out",    32'(OP_OUT),    32'(h.op));
    chk("sticky_cf", 32'(STICKY_CF), 32'(m_sticky));
    chk("zero_cnt",  32'(ZERO_CNT),  32'(m_zc8));
    chk("sat_count", 32'(s_count),   32'(mq.size()));
    chk("sat_head",  32'({s_out_valid, s_res_out, s_z_out, s_cf_out, s_op_out}),
                     32'({mq.size() != 0, h}));
    chk("sat_ready", 32'(s_in_ready), 32'(mq.size() < DEPTH));
    chk("sat_sticky", 32'(s_sticky),  32'(m_sticky));
    chk("sat_zero_cnt", 32'(s_zero_cnt), 32'(m_zc2));
  endtask

  // Advance one clock: update the model from the inputs the DUT samples, then compare.
  task automatic cycle();
    bit   push, pop, zp;
    ent_t e;
    @(posedge CLK);
    if (!RST_N) begin
      model_reset();
    end else begin
      push = IN_VALID && (mq.size() < DEPTH);
      pop  = OUT_READY && (mq.size() != 0);
      zp   = push && (RES == 4'd0);
      e    = '{res: RES, z: Z_IN, cf: CF_IN, op: OP_IN};
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (CLR_STAT) begin
        m_sticky = push && CF_IN;
        m_zc8 = zp ? 1 : 0;
        m_zc2 = zp ? 1 : 0;
      end else begin
        if (push && CF_IN) m_sticky = 1'b1;
        if (zp) begin
          m_zc8 = (m_zc8 < 255) ? m_zc8 + 1 : 255;
          m_zc2 = (m_zc2 < 3) ? m_zc2 + 1 : 3;
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input logic [3:0] r, input bit z, input bit cf,
                       input logic [2:0] op, input bit ordy, input bit clr);
    IN_VALID  = v;
    RES       = r;
    Z_IN      = z;
    CF_IN     = cf;
    OP_IN     = op;
    OUT_READY = ordy;
    CLR_STAT  = clr;
  endtask

  initial begin
    RST_N = 1'b0;
    model_reset();
    drive(0, 4'd0, 0, 0, 3'd0, 0, 0);
    cycle();
    cycle();
    chk("reset_out_valid", 32'(OUT_VALID), 32'd0);
    RST_N = 1'b1;
    #1;
    chk("post_reset_in_ready", 32'(IN_READY), 32'd1);

    // Single push with consumer stalled; head must hold for five cycles.
    drive(1, 4'hA, 0, 0, 3'd3, 0, 0);
    cycle();
    chk("single_res", 32'(RES_OUT), 32'hA);
    chk("single_op",  32'(OP_OUT),  32'd3);
    drive(0, 4'h0, 0, 0, 3'd0, 0, 0);
    repeat (5) cycle();
    chk("held_res", 32'(RES_OUT), 32'hA);
    drive(0, 4'h0, 0, 0, 3'd0, 1, 0);
    cycle();

    // Back-to-back pushes of 1..5 into a stalled FIFO; the fifth waits for space.
    for (int i = 1; i <= 5; i++) begin
      drive(1, 4'(i), i[0], 0, 3'(i), 0, 0);
      cycle();
    end
    chk("full_count", 32'(COUNT), 32'd4);
    chk("full_ready", 32'(IN_READY), 32'd0);
    // Full with simultaneous pop: pop only, then push/pop pairs hold occupancy.
    drive(1, 4'd5, 1, 0, 3'd5, 1, 0);
    cycle();
    chk("pop_only_count", 32'(COUNT), 32'd3);
    drive(1, 4'd6, 0, 1, 3'd6, 0, 0);
    cycle();
    chk("refill_count", 32'(COUNT), 32'd4);
    drive(0, 4'd0, 0, 0, 3'd0, 1, 0);
    repeat (5) cycle();
    chk("drained_count", 32'(COUNT), 32'd0);

    // Random stream with random back-pressure; pointers wrap many times.
    for (int i = 0; i < 60; i++) begin
      drive(($urandom % 4) != 0, 4'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 1'($urandom), ($urandom % 16) == 0);
      cycle();
    end
    drive(0, 4'd0, 0, 0, 3'd0, 1, 1);
    repeat (5) cycle();

    // Zero-result counting and sticky carry, including clear with concurrent push.
    drive(1, 4'd0, 1, 0, 3'd1, 1, 0);
    cycle();
    drive(1, 4'd0, 1, 1, 3'd2, 1, 0);
    cycle();
    drive(1, 4'd0, 0, 0, 3'd3, 1, 0);
    cycle();
    chk("zero_cnt_3", 32'(ZERO_CNT), 32'd3);
    chk("sticky_set", 32'(STICKY_CF), 32'd1);
    drive(1, 4'd0, 1, 1, 3'd4, 1, 1);
    cycle();
    chk("clr_push_zero_cnt", 32'(ZERO_CNT), 32'd1);
    chk("clr_push_sticky", 32'(STICKY_CF), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'd0, 1, 0, 3'(i), 1, 0);
      cycle();
    end
    chk("sat_zero_cnt_max", 32'(s_zero_cnt), 32'd3);
    chk("wide_zero_cnt", 32'(ZERO_CNT), 32'd6);
    // Nonzero results with Z_IN asserted must not count.
    drive(1, 4'd7, 1, 0, 3'd0, 1, 0);
    repeat (2) cycle();
    drive(0, 4'd0, 0, 0, 3'd0, 1, 0);
    repeat (2) cycle();

    // Fill to three entries, then assert reset asynchronously between edges.
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'(9 + i), 0, 1, 3'(i), 0, 0);
      cycle();
    end
    chk("pre_reset_count", 32'(COUNT), 32'd3);
    drive(0, 4'd0, 0, 0, 3'd0, 0, 0);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle();
    RST_N = 1'b1;
    drive(1, 4'hC, 0, 0, 3'd7, 0, 0);
    cycle();
    chk("after_reset_res", 32'(RES_OUT), 32'hC);
    drive(0, 4'd0, 0, 0, 3'd0, 1, 0);
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
